dnn_param_loader: RTL

DNN_PARAM_LOADER -- requirements
Module: dnn_param_loader

---
 rtl/dnn_pkg.sv | 40 ++++
 rtl/dnn_param_loader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dnn_pkg.sv
// Shared word type, frame geometry and FSM encoding for the DNN parameter loader.
// DNN_LOADER_CKSUM_EN adds the CKSUM state that validates a trailing checksum word.
package dnn_pkg;

    localparam int WORD_W    = 5;
    localparam int NUM_X     = 4;
    localparam int NUM_W1    = 16;
    localparam int NUM_W2    = 8;
    localparam int FRAME_LEN = NUM_X + NUM_W1 + NUM_W2;
    localparam int FRAME_W   = FRAME_LEN * WORD_W;

    typedef logic signed [WORD_W-1:0] dnn_word_t;
    typedef logic [FRAME_W-1:0]       frame_t;

`ifdef DNN_LOADER_CKSUM_EN
    typedef enum logic [1:0] {
        ST_LOAD,
        ST_CKSUM,
        ST_FIRE,
        ST_GAP
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_LOAD,
        ST_FIRE,
        ST_GAP
    } state_t;
`endif

    // Modulo-32 sum of every word in a packed frame; the carry out is dropped on purpose.
    function automatic logic [WORD_W-1:0] frame_sum(input frame_t f);
        logic [WORD_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            acc = acc + f[i*WORD_W +: WORD_W];
        end
        return acc;
    endfunction

endpackage

// File: rtl/dnn_param_loader.sv
// Streams 28 signed parameter words into a shadow frame and publishes them to dnn_top in one edge.
// DNN_LOADER_CKSUM_EN: a 29th checksum word must match before the frame is published.
module dnn_param_loader
    import dnn_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  dnn_word_t                s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [NUM_X*WORD_W-1:0]  x_flat,
    output logic [NUM_W1*WORD_W-1:0] w1_flat,
    output logic [NUM_W2*WORD_W-1:0] w2_flat,
    output logic                     in_ready,
    output logic                     busy,
    output logic                     frame_err
);

    localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);
    localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    state_t     state;
    state_t     state_next;
    logic [4:0] cnt;
    logic [3:0] gap_cnt;
    frame_t     shadow;
    frame_t     shadow_next;
    frame_t     params;
    logic       transfer;
    logic       fire_entry;

    assign transfer   = s_valid && s_ready;
    assign fire_entry = (state_next == ST_FIRE) && (state != ST_FIRE);

`ifdef DNN_LOADER_CKSUM_EN
    logic cksum_ok;
    assign cksum_ok = ($unsigned(s_data) == frame_sum(shadow));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD: begin
                if (transfer && (cnt == LAST_IDX)) begin
`ifdef DNN_LOADER_CKSUM_EN
                    state_next = ST_CKSUM;
`else
                    state_next = ST_FIRE;
`endif
                end
            end
`ifdef DNN_LOADER_CKSUM_EN
            ST_CKSUM: begin
                if (transfer) begin
                    state_next = cksum_ok ? ST_FIRE : ST_LOAD;
                end
            end
`endif
            ST_FIRE: begin
                state_next = (GAP_CYCLES == 0) ? ST_LOAD : ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end

    // The ready gate uses rst_n directly so nothing is accepted while reset is held.
    always_comb begin
        s_ready  = 1'b0;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state)
            ST_LOAD: begin
                s_ready = rst_n;
                busy    = (cnt != 5'd0);
            end
`ifdef DNN_LOADER_CKSUM_EN
            ST_CKSUM: begin
                s_ready = rst_n;
                busy    = 1'b1;
            end
`endif
            ST_FIRE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_GAP: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // The final word is folded in here so the publish edge sees the complete frame.
    always_comb begin
        shadow_next = shadow;
        if (transfer && (state == ST_LOAD)) begin
            shadow_next[cnt*WORD_W +: WORD_W] = s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= 5'd0;
            gap_cnt <= 4'd0;
            shadow  <= '0;
            params  <= '0;
        end else begin
            shadow <= shadow_next;
            if (fire_entry) begin
                params <= shadow_next;
            end
            if (transfer && (state == ST_LOAD)) begin
                cnt <= (cnt == LAST_IDX) ? 5'd0 : (cnt + 5'd1);
            end
            if (state == ST_FIRE) begin
                gap_cnt <= 4'd0;
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + 4'd1;
            end
        end
    end

`ifdef DNN_LOADER_CKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= (state == ST_CKSUM) && transfer && !cksum_ok;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

    // Stream index order already matches the flat port layout, so the outputs are plain slices.
    assign x_flat  = params[0 +: NUM_X*WORD_W];
    assign w1_flat = params[NUM_X*WORD_W +: NUM_W1*WORD_W];
    assign w2_flat = params[(NUM_X+NUM_W1)*WORD_W +: NUM_W2*WORD_W];

endmodule
